// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor: sequencer state encoding,
// default instruction width and the instruction field layout used to build programs.
package coproc_pkg;

  localparam int unsigned INSTR_W_DEF = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Instruction layout: {opcode, matrix select, row, column, data}
  localparam int unsigned OPC_LSB  = 18;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned MSEL_LSB = 16;
  localparam int unsigned MSEL_W   = 2;
  localparam int unsigned ROW_LSB  = 13;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned COL_LSB  = 10;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned DAT_LSB  = 0;
  localparam int unsigned DAT_W    = 10;

  function automatic logic [INSTR_W_DEF-1:0] make_instr(
    input logic [OPC_W-1:0]  opc,
    input logic [MSEL_W-1:0] msel,
    input logic [ROW_W-1:0]  row,
    input logic [COL_W-1:0]  col,
    input logic [DAT_W-1:0]  data
  );
    return {opc, msel, row, col, data};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on the accepted released->pressed transition of an active-low button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press   <= level_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction feeder for the matrix coprocessor: a loadable table issued over
// valid/ready one entry per step press, or as a paced burst in auto mode.
module instr_sequencer
  import coproc_pkg::*;
#(
  parameter int unsigned INSTR_W         = INSTR_W_DEF,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_GAP        = 16,
  localparam int unsigned IW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_step_n,
  input  logic               btn_run_n,
  input  logic               mode_auto,
  input  logic               wrap_en,
  input  logic [LW-1:0]      len,
  input  logic               prog_we,
  input  logic [IW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instr_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [IW-1:0]      idx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned GW = (AUTO_GAP > 1) ? $clog2(AUTO_GAP) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(AUTO_GAP - 1);

  seq_state_e        state_q, state_d;
  logic              step_p, run_p;
  logic              auto_q, auto_d;
  logic              stop_q;
  logic [GW-1:0]     gap_q;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [LW-1:0]     len_clamp;
  logic              last, xfer, load_instr;
  logic              valid_d, busy_d, done_d;
  logic [IW-1:0]     idx_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_step_n), .press(step_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_run_n), .press(run_p)
  );

  assign len_clamp = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
  assign xfer      = (state_q == ST_ISSUE) && instr_ready;
  assign last      = (idx == IW'(len_clamp - LW'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; auto run wins over a simultaneous step press
  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    case (state_q)
      ST_IDLE: begin
        if (len_clamp != '0) begin
          if (mode_auto && run_p) begin
            state_d = ST_ISSUE;
            auto_d  = 1'b1;
          end else if (step_p) begin
            state_d = ST_ISSUE;
            auto_d  = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          if (last && !wrap_en)       state_d = ST_DONE;
          else if (!auto_q)           state_d = ST_IDLE;
          else if (stop_q || run_p)   state_d = ST_IDLE;
          else                        state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (run_p)                 state_d = ST_IDLE;
        else if (gap_q == GAP_MAX) state_d = ST_ISSUE;
      end
      ST_DONE: begin
        if (step_p || run_p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    valid_d    = (state_d == ST_ISSUE);
    busy_d     = (state_d == ST_ISSUE) || (state_d == ST_GAP);
    done_d     = (state_d == ST_DONE);
    load_instr = (state_q != ST_ISSUE) && (state_d == ST_ISSUE);
    idx_d      = idx;
    if (xfer) begin
      idx_d = last ? '0 : IW'(idx + IW'(1));
    end else if ((state_q == ST_DONE) && (state_d == ST_IDLE)) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q      <= 1'b0;
      stop_q      <= 1'b0;
      gap_q       <= '0;
      idx         <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      auto_q      <= auto_d;
      stop_q      <= (state_d == ST_ISSUE) &&
                     (stop_q || ((state_q == ST_ISSUE) && auto_q && run_p));
      gap_q       <= (state_q == ST_GAP) ? gap_q + GW'(1) : '0;
      idx         <= idx_d;
      instr_valid <= valid_d;
      busy        <= busy_d;
      done        <= done_d;
      if (load_instr) instr_data <= mem_q[idx];
    end
  end

  // Program table; frozen while a program is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (prog_we && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with short debounce and gap settings.
module tb_instr_sequencer;

  localparam int unsigned INSTR_W = 22;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned IW      = 3;
  localparam int unsigned LW      = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               btn_step_n, btn_run_n, mode_auto, wrap_en;
  logic [LW-1:0]      len;
  logic               prog_we;
  logic [IW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [INSTR_W-1:0] instr_data;
  logic               instr_valid, instr_ready;
  logic [IW-1:0]      idx;
  logic               busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [INSTR_W-1:0] xq[$];
  int                 tq[$];

  instr_sequencer #(
    .INSTR_W(INSTR_W), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(4), .AUTO_GAP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_step_n(btn_step_n), .btn_run_n(btn_run_n),
    .mode_auto(mode_auto), .wrap_en(wrap_en), .len(len), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .instr_data(instr_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .idx(idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Transfer log
  always @(posedge clk) begin
    cyc++;
    if (rst_n && instr_valid && instr_ready) begin
      xq.push_back(instr_data);
      tq.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic prog(input int unsigned a, input logic [INSTR_W-1:0] d);
    prog_we = 1'b1; prog_addr = IW'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic press(input bit run, input int n_low);
    if (run) btn_run_n = 1'b0; else btn_step_n = 1'b0;
    cycles(n_low);
    btn_run_n = 1'b1; btn_step_n = 1'b1;
    cycles(10);
  endtask

  task automatic wait_xfers(input int n, input int bound);
    int k = 0;
    while (xq.size() < n && k < bound) begin @(negedge clk); k++; end
    check("xfer_count", xq.size(), n);
  endtask

  task automatic wait_valid(input int bound);
    int k = 0;
    while (!instr_valid && k < bound) begin @(negedge clk); k++; end
    check("valid_seen", instr_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; btn_step_n = 1'b1; btn_run_n = 1'b1; mode_auto = 1'b0;
    wrap_en = 1'b0; len = 4'd3; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    instr_ready = 1'b1;
    cycles(3);
    check("rst_valid", instr_valid, 0);
    check("rst_data", instr_data, 0);
    check("rst_idx", idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    cycles(2);

    // Step mode: three presses issue three entries, then DONE
    prog(0, 22'h0A); prog(1, 22'h0B); prog(2, 22'h0C);
    press(0, 8);
    check("step1_idx", idx, 1);
    check("step1_busy", busy, 0);
    press(0, 8);
    press(0, 8);
    check("step_cnt", xq.size(), 3);
    check("step_d0", xq[0], 22'h0A);
    check("step_d1", xq[1], 22'h0B);
    check("step_d2", xq[2], 22'h0C);
    check("step_done", done, 1);
    check("step_idx0", idx, 0);
    press(0, 8);
    check("done_exit", done, 0);
    check("done_noissue", xq.size(), 3);

    // Auto mode, no wrap: paced transfers then DONE
    xq.delete(); tq.delete();
    mode_auto = 1'b1;
    btn_run_n = 1'b0;
    wait_xfers(3, 60);
    btn_run_n = 1'b1;
    cycles(10);
    check("auto_d0", xq[0], 22'h0A);
    check("auto_d2", xq[2], 22'h0C);
    check("auto_gap1", tq[1] - tq[0], 4);
    check("auto_gap2", tq[2] - tq[1], 4);
    check("auto_done", done, 1);
    press(1, 8);
    check("auto_exit", done, 0);
    check("auto_noissue", xq.size(), 3);
    check("auto_idx", idx, 0);

    // Auto with wrap, backpressure on entry 1, stop during ISSUE
    xq.delete(); tq.delete();
    wrap_en = 1'b1;
    btn_run_n = 1'b0;
    wait_xfers(1, 40);
    instr_ready = 1'b0;
    btn_run_n = 1'b1;
    wait_valid(20);
    check("bp_data0", instr_data, 22'h0B);
    cycles(5);
    check("bp_valid", instr_valid, 1);
    check("bp_data1", instr_data, 22'h0B);
    check("bp_hold", xq.size(), 1);
    instr_ready = 1'b1;
    wait_xfers(4, 40);
    instr_ready = 1'b0;
    check("wrap_d2", xq[2], 22'h0C);
    check("wrap_d3", xq[3], 22'h0A);
    wait_valid(20);
    btn_run_n = 1'b0;
    cycles(8);
    btn_run_n = 1'b1;
    check("stop_still_valid", instr_valid, 1);
    instr_ready = 1'b1;
    cycles(12);
    check("stop_cnt", xq.size(), 5);
    check("stop_d4", xq[4], 22'h0B);
    check("stop_busy", busy, 0);
    check("stop_idx", idx, 2);

    // Debounce: a 2-cycle glitch is filtered, a 6-cycle low is one press
    wrap_en = 1'b0; mode_auto = 1'b0;
    press(0, 2);
    cycles(4);
    check("glitch_cnt", xq.size(), 5);
    check("glitch_busy", busy, 0);
    press(0, 6);
    check("press6_cnt", xq.size(), 6);
    check("press6_data", xq[5], 22'h0C);
    check("press6_done", done, 1);
    press(0, 8);
    check("press6_exit", done, 0);

    // Empty program ignores presses
    len = 4'd0; mode_auto = 1'b1;
    press(0, 8);
    press(1, 8);
    check("len0_cnt", xq.size(), 6);
    check("len0_valid", instr_valid, 0);
    check("len0_busy", busy, 0);

    // len clamps to DEPTH; write during GAP is ignored
    xq.delete(); tq.delete();
    prog(3, 22'h0D); prog(4, 22'h0E); prog(5, 22'h0F); prog(6, 22'h10); prog(7, 22'h11);
    len = 4'd12; wrap_en = 1'b1;
    btn_run_n = 1'b0;
    wait_xfers(9, 80);
    btn_run_n = 1'b1;
    check("clamp_d7", xq[7], 22'h11);
    check("clamp_wrap", xq[8], 22'h0A);
    check("gap_state", busy & ~instr_valid, 1);
    prog(2, 22'h3FFFFF);
    wait_xfers(11, 40);
    check("gap_write", xq[10], 22'h0C);
    press(1, 8);
    cycles(12);
    check("clamp_stop", busy, 0);

    // Asynchronous reset in the middle of ISSUE
    len = 4'd3; wrap_en = 1'b0; mode_auto = 1'b0; instr_ready = 1'b0;
    btn_step_n = 1'b0;
    wait_valid(30);
    rst_n = 1'b0;
    #1;
    check("arst_valid", instr_valid, 0);
    check("arst_idx", idx, 0);
    check("arst_busy", busy, 0);
    btn_step_n = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    xq.delete(); tq.delete();
    cycles(2);
    press(0, 8);
    check("arst_cnt", xq.size(), 1);
    check("arst_table", xq[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
